lenet_layer_sequencer: RTL and testbench
========================================

# lenet_layer_sequencer

Table-driven, parametrised layer sequencer for the CNN accelerator. It generalises the fixed two-layer LeNet-5 controller to up to MAX_LAYERS host-programmable layer descriptors. Per layer it runs the weight-load handshake, presents that layer's core configuration, pulses the systolic core start and waits for core done. Over the fixed flow it adds optional weight-load skip, a per-layer watchdog timeout, host abort, error reporting and a run-cycle counter. It sits between host/testbench and the systolic wrapper.

## Interface
- MAX_LAYERS, 8, descriptor table depth; IDX_W = $clog2(MAX_LAYERS)
- ADDR_W, 32, SRAM base-address width
- DIM_W, 32, image width/height field width
- CH_W, 16, input-channel-count width
- TO_W, 24, watchdog counter width
- DESC_W, derived, = 2*ADDR_W + CH_W + 2*DIM_W + 14
- clk_i  in  1  clock
- rst_async_n_i  in  1  asynchronous, active-low reset
- desc_we_i  in  1  descriptor table write strobe
- desc_idx_i  in  IDX_W  descriptor table write index
- desc_wdata_i  in  DESC_W  packed descriptor, LSB first: skip_load[0], do_bias[1], do_relu[2], do_pool[3], do_quant[4], kernel_r[8:5], quant_shift[13:9], img_w, img_h, num_ch, read_base, write_base
- num_layers_i  in  IDX_W+1  layer count, sampled at start; legal range 0..MAX_LAYERS
- timeout_i  in  TO_W  watchdog limit in cycles; 0 disables the watchdog; sampled at start
- host_start_i  in  1  level start request
- host_abort_i  in  1  abort request
- host_busy_o  out  1  high in every state except IDLE, DONE and ERR
- host_done_o  out  1  high in DONE
- host_err_o  out  1  high in ERR
- err_code_o  out  2  0 none, 1 timeout, 2 abort, 3 illegal num_layers
- cur_layer_o  out  IDX_W  index of the active layer
- run_cycles_o  out  32  cycles spent busy in the last run; saturates at all-ones
- req_load_weight_o  out  1  weight-load request
- layer_id_o  out  4  layer index + 1, valid while req_load_weight_o is high
- weight_loaded_i  in  1  weight load complete
- cfg_img_w_o, cfg_img_h_o  out  DIM_W  image dimensions
- cfg_kernel_r_o  out  4  kernel size
- cfg_do_bias_o, cfg_do_relu_o, cfg_do_pool_o, cfg_do_quant_o  out  1  mode enables
- cfg_quant_shift_o  out  5  quantisation shift
- cfg_num_input_channels_o  out  CH_W  input-channel count
- cfg_read_base_o, cfg_write_base_o  out  ADDR_W  SRAM base addresses
- core_start_o  out  1  one-cycle start pulse to the core
- core_done_i  in  1  core done

## Operation
- Descriptor table is MAX_LAYERS x DESC_W registers.
  - Written while host_busy_o is low; writes while busy are dropped.
  - Table is not reset.
- States are IDLE, LOAD, RUN, WAIT, NEXT, DONE, ERR.
- IDLE, host_start_i high:
  - num_layers_i == 0 goes to DONE.
  - num_layers_i > MAX_LAYERS goes to ERR with err_code 3.
  - Otherwise goes to LOAD with idx = 0. num_layers_i and timeout_i are latched, run_cycles is cleared and err_code is cleared.
- cfg_* registers load from table[idx] on every entry to LOAD. They then hold unchanged until the next LOAD entry, including through DONE, ERR and IDLE.
- LOAD:
  - skip_load = 1: go to RUN without asserting req_load_weight_o.
  - skip_load = 0: assert req_load_weight_o with layer_id_o = idx + 1, and stay until weight_loaded_i is sampled high.
- RUN: core_start_o = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Wait for core_done_i, then go to NEXT.
  - core_done_i seen in any other state is ignored.
- NEXT: if idx == num_layers - 1 go to DONE; otherwise idx++ and go to LOAD.
- Watchdog:
  - Counter clears on entry to LOAD and counts every cycle in LOAD, RUN and WAIT.
  - If timeout ≠ 0 and the counter reaches timeout, go to ERR with err_code 1.
- host_abort_i high in any busy state: go to ERR with err_code 2. Abort has priority over done, loaded and timeout in the same cycle.
- DONE and ERR return to IDLE once host_start_i is sampled low.
- run_cycles increments each cycle host_busy_o is high and holds after the run.

## Timing
- Reset state:
  - State is IDLE.
  - All outputs, cfg_* registers, idx, counters and err_code are 0.
- Reset may assert mid-run and forces IDLE immediately. No core_start_o is emitted after reset.
- host_start_i sampled high at cycle 0:
  - LOAD at cycle 1.
  - req_load_weight_o and cfg_* valid from cycle 1.
- weight_loaded_i sampled at cycle k: core_start_o at k+1, WAIT at k+2.
- With skip_load = 1: LOAD entry at cycle t gives core_start_o at t+1.
- core_done_i sampled at cycle m: NEXT at m+1, then LOAD (next layer) or DONE at m+2.
- cfg_* are stable at least 1 cycle before core_start_o and through the whole of WAIT.
- Outputs are registered or decoded from state only. There is no combinational input-to-output path.

## Test plan
- LeNet-5 flow:
  - Program desc0 = {32x32, k5, all flags on, shift 8, ch 1, rd 0x000, wr 0x400} and desc1 = {14x14, k5, ch 6, rd 0x400, wr 0x800}; num_layers = 2.
  - Required: layer_id_o 1 then 2, two core_start_o pulses, cfg matching each descriptor, then DONE.
  - Dropping host_start_i returns to IDLE.
- num_layers = 8 with skip_load set in layers 3 and 5:
  - Required: exactly 6 load requests, 8 start pulses, cur_layer_o running 0..7.
- timeout = 100, core_done_i never asserted:
  - Required: ERR at LOAD entry + 100 with err_code 1, and no further core_start_o.
- host_abort_i in the same cycle as core_done_i in WAIT:
  - Required: ERR with err_code 2, with no NEXT/LOAD.
- num_layers = 0:
  - Required: DONE at cycle 1 with no req or start pulses.
- num_layers = 9 (MAX 8):
  - Required: ERR with err_code 3.
- desc write while busy:
  - Required: table unchanged. Verify by rerunning and comparing the cfg outputs.
- Reset asserted in WAIT:
  - Required: all outputs 0 and IDLE.
  - run_cycles equals the busy cycle count on a clean run.

Source files
------------

// File: rtl/lenet_layer_sequencer.sv
// Table-driven layer sequencer for the CNN accelerator.
// Walks host-programmed layer descriptors through load/start/wait.
module lenet_layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W = 32,
  parameter int CH_W = 16,
  parameter int TO_W = 24,
  localparam int IDX_W = $clog2(MAX_LAYERS),
  localparam int DESC_W = 2*ADDR_W + CH_W + 2*DIM_W + 14
) (
  input  logic              clk_i,
  input  logic              rst_async_n_i,
  input  logic              desc_we_i,
  input  logic [IDX_W-1:0]  desc_idx_i,
  input  logic [DESC_W-1:0] desc_wdata_i,
  input  logic [IDX_W:0]    num_layers_i,
  input  logic [TO_W-1:0]   timeout_i,
  input  logic              host_start_i,
  input  logic              host_abort_i,
  output logic              host_busy_o,
  output logic              host_done_o,
  output logic              host_err_o,
  output logic [1:0]        err_code_o,
  output logic [IDX_W-1:0]  cur_layer_o,
  output logic [31:0]       run_cycles_o,
  output logic              req_load_weight_o,
  output logic [3:0]        layer_id_o,
  input  logic              weight_loaded_i,
  output logic [DIM_W-1:0]  cfg_img_w_o,
  output logic [DIM_W-1:0]  cfg_img_h_o,
  output logic [3:0]        cfg_kernel_r_o,
  output logic              cfg_do_bias_o,
  output logic              cfg_do_relu_o,
  output logic              cfg_do_pool_o,
  output logic              cfg_do_quant_o,
  output logic [4:0]        cfg_quant_shift_o,
  output logic [CH_W-1:0]   cfg_num_input_channels_o,
  output logic [ADDR_W-1:0] cfg_read_base_o,
  output logic [ADDR_W-1:0] cfg_write_base_o,
  output logic              core_start_o,
  input  logic              core_done_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam int O_W  = 14;
  localparam int O_H  = O_W + DIM_W;
  localparam int O_CH = O_H + DIM_W;
  localparam int O_RB = O_CH + CH_W;
  localparam int O_WB = O_RB + ADDR_W;

  logic [DESC_W-1:0] table_q [MAX_LAYERS];
  logic [DESC_W-1:0] ld_desc;
  logic [2:0]        state, nxt;
  logic [IDX_W-1:0]  idx, ld_idx;
  logic [IDX_W:0]    nl_q;
  logic [TO_W-1:0]   to_q, wd;
  logic [1:0]        err_q, nerr;
  logic [31:0]       cyc_q;
  logic              skip_q, ld, busy, to_hit, last, wd_en, go;

  assign busy   = (state == S_LOAD) || (state == S_RUN) ||
                  (state == S_WAIT) || (state == S_NEXT);
  assign wd_en  = (state == S_LOAD) || (state == S_RUN) ||
                  (state == S_WAIT);
  assign to_hit = (to_q != '0) && (wd == to_q - 1'b1);
  assign last   = ({1'b0, idx} == nl_q - 1'b1);
  assign go     = (state == S_IDLE) && (nxt == S_LOAD);
  assign ld_desc = table_q[ld_idx];

  // Descriptor table: host writes accepted only while not busy
  always_ff @(posedge clk_i) begin
    if (desc_we_i && !busy)
      table_q[desc_idx_i] <= desc_wdata_i;
  end

  // Next-state decode; abort outranks timeout, timeout outranks progress
  always_comb begin
    nxt    = state;
    nerr   = err_q;
    ld     = 1'b0;
    ld_idx = idx;
    case (state)
      S_IDLE: begin
        if (host_start_i) begin
          if (num_layers_i == '0) begin
            nxt = S_DONE;
          end else if (num_layers_i > (IDX_W+1)'(MAX_LAYERS)) begin
            nxt  = S_ERR;
            nerr = 2'd3;
          end else begin
            nxt    = S_LOAD;
            nerr   = 2'd0;
            ld     = 1'b1;
            ld_idx = '0;
          end
        end
      end
      S_LOAD, S_RUN, S_WAIT: begin
        if (host_abort_i) begin
          nxt  = S_ERR;
          nerr = 2'd2;
        end else if (to_hit) begin
          nxt  = S_ERR;
          nerr = 2'd1;
        end else if (state == S_LOAD) begin
          if (skip_q || weight_loaded_i) nxt = S_RUN;
        end else if (state == S_RUN) begin
          nxt = S_WAIT;
        end else if (core_done_i) begin
          nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (host_abort_i) begin
          nxt  = S_ERR;
          nerr = 2'd2;
        end else if (last) begin
          nxt = S_DONE;
        end else begin
          nxt    = S_LOAD;
          ld     = 1'b1;
          ld_idx = idx + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (!host_start_i) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State, run bookkeeping and per-layer config capture on LOAD entry
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state                    <= S_IDLE;
      err_q                    <= '0;
      idx                      <= '0;
      nl_q                     <= '0;
      to_q                     <= '0;
      wd                       <= '0;
      cyc_q                    <= '0;
      skip_q                   <= 1'b0;
      cfg_do_bias_o            <= 1'b0;
      cfg_do_relu_o            <= 1'b0;
      cfg_do_pool_o            <= 1'b0;
      cfg_do_quant_o           <= 1'b0;
      cfg_kernel_r_o           <= '0;
      cfg_quant_shift_o        <= '0;
      cfg_img_w_o              <= '0;
      cfg_img_h_o              <= '0;
      cfg_num_input_channels_o <= '0;
      cfg_read_base_o          <= '0;
      cfg_write_base_o         <= '0;
    end else begin
      state <= nxt;
      err_q <= nerr;
      if (go) begin
        nl_q  <= num_layers_i;
        to_q  <= timeout_i;
        cyc_q <= '0;
      end else if (busy && cyc_q != '1) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (ld) begin
        idx                      <= ld_idx;
        wd                       <= '0;
        skip_q                   <= ld_desc[0];
        cfg_do_bias_o            <= ld_desc[1];
        cfg_do_relu_o            <= ld_desc[2];
        cfg_do_pool_o            <= ld_desc[3];
        cfg_do_quant_o           <= ld_desc[4];
        cfg_kernel_r_o           <= ld_desc[8:5];
        cfg_quant_shift_o        <= ld_desc[13:9];
        cfg_img_w_o              <= ld_desc[O_W +: DIM_W];
        cfg_img_h_o              <= ld_desc[O_H +: DIM_W];
        cfg_num_input_channels_o <= ld_desc[O_CH +: CH_W];
        cfg_read_base_o          <= ld_desc[O_RB +: ADDR_W];
        cfg_write_base_o         <= ld_desc[O_WB +: ADDR_W];
      end else if (wd_en) begin
        wd <= wd + 1'b1;
      end
    end
  end

  assign host_busy_o       = busy;
  assign host_done_o       = (state == S_DONE);
  assign host_err_o        = (state == S_ERR);
  assign err_code_o        = err_q;
  assign cur_layer_o       = idx;
  assign run_cycles_o      = cyc_q;
  assign req_load_weight_o = (state == S_LOAD) && !skip_q;
  assign layer_id_o        = req_load_weight_o ? 4'(idx) + 4'd1 : 4'd0;
  assign core_start_o      = (state == S_RUN);

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Bench for lenet_layer_sequencer: reactive host/core model,
// expectations from descriptor table and chosen handshake delays.
module tb_lenet_layer_sequencer;

  localparam int IDX_W  = 3;
  localparam int DESC_W = 158;

  logic              clk_i = 1'b0;
  logic              rst_async_n_i = 1'b1;
  logic              desc_we_i = 1'b0;
  logic [IDX_W-1:0]  desc_idx_i = '0;
  logic [DESC_W-1:0] desc_wdata_i = '0;
  logic [IDX_W:0]    num_layers_i = '0;
  logic [23:0]       timeout_i = '0;
  logic              host_start_i = 1'b0;
  logic              host_abort_i = 1'b0;
  logic              weight_loaded_i = 1'b0;
  logic              core_done_i = 1'b0;
  logic              host_busy_o, host_done_o, host_err_o;
  logic [1:0]        err_code_o;
  logic [IDX_W-1:0]  cur_layer_o;
  logic [31:0]       run_cycles_o;
  logic              req_load_weight_o;
  logic [3:0]        layer_id_o;
  logic [31:0]       cfg_img_w_o, cfg_img_h_o;
  logic [3:0]        cfg_kernel_r_o;
  logic              cfg_do_bias_o, cfg_do_relu_o;
  logic              cfg_do_pool_o, cfg_do_quant_o;
  logic [4:0]        cfg_quant_shift_o;
  logic [15:0]       cfg_num_input_channels_o;
  logic [31:0]       cfg_read_base_o, cfg_write_base_o;
  logic              core_start_o;

  lenet_layer_sequencer dut (
    .clk_i(clk_i), .rst_async_n_i(rst_async_n_i),
    .desc_we_i(desc_we_i), .desc_idx_i(desc_idx_i),
    .desc_wdata_i(desc_wdata_i), .num_layers_i(num_layers_i),
    .timeout_i(timeout_i), .host_start_i(host_start_i),
    .host_abort_i(host_abort_i), .host_busy_o(host_busy_o),
    .host_done_o(host_done_o), .host_err_o(host_err_o),
    .err_code_o(err_code_o), .cur_layer_o(cur_layer_o),
    .run_cycles_o(run_cycles_o),
    .req_load_weight_o(req_load_weight_o),
    .layer_id_o(layer_id_o), .weight_loaded_i(weight_loaded_i),
    .cfg_img_w_o(cfg_img_w_o), .cfg_img_h_o(cfg_img_h_o),
    .cfg_kernel_r_o(cfg_kernel_r_o),
    .cfg_do_bias_o(cfg_do_bias_o), .cfg_do_relu_o(cfg_do_relu_o),
    .cfg_do_pool_o(cfg_do_pool_o), .cfg_do_quant_o(cfg_do_quant_o),
    .cfg_quant_shift_o(cfg_quant_shift_o),
    .cfg_num_input_channels_o(cfg_num_input_channels_o),
    .cfg_read_base_o(cfg_read_base_o),
    .cfg_write_base_o(cfg_write_base_o),
    .core_start_o(core_start_o), .core_done_i(core_done_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [DESC_W-1:0] mdesc [8];
  int r_nreq, r_nstart, r_end_rel, r_abort_rel, r_busy;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DESC_W-1:0] pack(
    input bit sk, input bit b, input bit r, input bit p, input bit q,
    input logic [3:0] k, input logic [4:0] sh,
    input logic [31:0] w, input logic [31:0] h, input logic [15:0] ch,
    input logic [31:0] rb, input logic [31:0] wb);
    return {wb, rb, ch, h, w, sh, k, q, p, r, b, sk};
  endfunction

  function automatic logic [DESC_W-1:0] noskip(input logic [DESC_W-1:0] d);
    logic [DESC_W-1:0] t;
    t = d;
    t[0] = 1'b0;
    return t;
  endfunction

  function automatic logic [DESC_W-1:0] cfg_vec();
    return {cfg_write_base_o, cfg_read_base_o, cfg_num_input_channels_o,
            cfg_img_h_o, cfg_img_w_o, cfg_quant_shift_o, cfg_kernel_r_o,
            cfg_do_quant_o, cfg_do_pool_o, cfg_do_relu_o, cfg_do_bias_o,
            1'b0};
  endfunction

  function automatic logic [255:0] out_vec();
    return {host_busy_o, host_done_o, host_err_o, err_code_o,
            cur_layer_o, run_cycles_o, req_load_weight_o, layer_id_o,
            core_start_o, cfg_vec()};
  endfunction

  task automatic wr(input int i, input logic [DESC_W-1:0] d);
    @(negedge clk_i);
    desc_we_i = 1'b1;
    desc_idx_i = IDX_W'(i);
    desc_wdata_i = d;
    mdesc[i] = d;
    @(negedge clk_i);
    desc_we_i = 1'b0;
  endtask

  task automatic drop();
    host_start_i = 1'b0;
    @(negedge clk_i);
    chk("back_idle", {host_busy_o, host_done_o, host_err_o}, 0);
  endtask

  // Runs one flow acting as host, weight loader and core.
  task automatic run(input int n, input int to, input int abort_l,
                     input bit hang, input bit wr_busy);
    int l_exp, wl_lim, wl_cnt, d_lim, d_cnt, mc;
    bit waiting, req_prev;
    r_nreq = 0; r_nstart = 0; r_end_rel = -1; r_abort_rel = -1;
    l_exp = 0; wl_lim = 0; wl_cnt = 0; d_lim = 0; d_cnt = 0; mc = 0;
    waiting = 0; req_prev = 0;
    @(negedge clk_i);
    num_layers_i = (IDX_W+1)'(n);
    timeout_i = 24'(to);
    host_start_i = 1'b1;
    for (int rel = 1; rel <= 2000; rel++) begin
      @(negedge clk_i);
      weight_loaded_i = 1'b0;
      core_done_i = 1'b0;
      host_abort_i = 1'b0;
      desc_we_i = 1'b0;
      if (host_done_o || host_err_o) begin
        r_end_rel = rel;
        break;
      end
      if (rel == 1) chk("start_latency", host_busy_o, 1);
      if (wr_busy && rel == 1) begin
        desc_we_i = 1'b1;
        desc_idx_i = IDX_W'(1);
        desc_wdata_i = '1;
      end
      if (req_load_weight_o) begin
        if (!req_prev) begin
          r_nreq++;
          chk("layer_id", layer_id_o, l_exp + 1);
          chk("req_noskip", mdesc[l_exp][0], 0);
          wl_lim = $urandom_range(0, 3);
          wl_cnt = 0;
          mc += wl_lim + 1;
        end
        if (wl_cnt == wl_lim) weight_loaded_i = 1'b1;
        wl_cnt++;
      end
      req_prev = req_load_weight_o;
      if (core_start_o) begin
        r_nstart++;
        chk("cur_layer", cur_layer_o, l_exp);
        chk("cfg", cfg_vec(), noskip(mdesc[l_exp]));
        if (mdesc[l_exp][0]) mc += 1;
        d_lim = $urandom_range(0, 3);
        d_cnt = 0;
        waiting = 1;
        mc += d_lim + 3;
      end else if (waiting) begin
        if (d_cnt == d_lim) begin
          waiting = 0;
          if (!hang) core_done_i = 1'b1;
          if (abort_l == l_exp) begin
            host_abort_i = 1'b1;
            r_abort_rel = rel;
          end
          l_exp++;
        end else begin
          d_cnt++;
        end
      end
    end
    chk("run_bounded", r_end_rel > 0, 1);
    r_busy = mc;
  endtask

  initial begin
    logic [191:0] rnd;
    int acc;
    bit seen;
    #2 rst_async_n_i = 1'b0;
    #1 chk("reset_outs", out_vec(), 0);
    repeat (2) @(negedge clk_i);
    rst_async_n_i = 1'b1;

    wr(0, pack(0, 1, 1, 1, 1, 4'd5, 5'd8, 32, 32, 16'd1, 32'h0, 32'h400));
    wr(1, pack(0, 1, 1, 0, 1, 4'd5, 5'd8, 14, 14, 16'd6, 32'h400, 32'h800));
    run(2, 0, -1, 0, 1);
    chk("lenet_done", host_done_o, 1);
    chk("lenet_nreq", r_nreq, 2);
    chk("lenet_nstart", r_nstart, 2);
    chk("lenet_err_code", err_code_o, 0);
    chk("lenet_cycles", run_cycles_o, r_busy);
    drop();
    chk("cfg_hold_idle", cfg_vec(), noskip(mdesc[1]));
    run(2, 0, -1, 0, 0);
    chk("rerun_nstart", r_nstart, 2);
    chk("rerun_cycles", run_cycles_o, r_busy);
    drop();

    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rnd[0] = (i == 3 || i == 5);
      wr(i, rnd[DESC_W-1:0]);
    end
    run(8, 50, -1, 0, 0);
    chk("l8_done", host_done_o, 1);
    chk("l8_nreq", r_nreq, 6);
    chk("l8_nstart", r_nstart, 8);
    chk("l8_cycles", run_cycles_o, r_busy);
    drop();

    run(1, 100, -1, 1, 0);
    chk("to_err", host_err_o, 1);
    chk("to_code", err_code_o, 1);
    chk("to_time", r_end_rel, 101);
    chk("to_nstart", r_nstart, 1);
    chk("to_cycles", run_cycles_o, 100);
    acc = 0;
    repeat (3) begin
      @(negedge clk_i);
      acc += int'(core_start_o);
    end
    chk("to_no_start", acc, 0);
    drop();

    run(2, 0, 0, 0, 0);
    chk("abort_code", err_code_o, 2);
    chk("abort_time", r_end_rel, r_abort_rel + 1);
    chk("abort_nstart", r_nstart, 1);
    drop();

    run(0, 0, -1, 0, 0);
    chk("zero_done", host_done_o, 1);
    chk("zero_time", r_end_rel, 1);
    chk("zero_pulses", r_nreq + r_nstart, 0);
    drop();

    run(9, 0, -1, 0, 0);
    chk("nl9_err", host_err_o, 1);
    chk("nl9_code", err_code_o, 3);
    chk("nl9_time", r_end_rel, 1);
    drop();

    num_layers_i = 4'd2;
    timeout_i = '0;
    host_start_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      weight_loaded_i = req_load_weight_o;
      if (core_start_o) seen = 1;
    end
    chk("rst_start_seen", seen, 1);
    @(negedge clk_i);
    weight_loaded_i = 1'b0;
    host_start_i = 1'b0;
    rst_async_n_i = 1'b0;
    #1 chk("rst_outs", out_vec(), 0);
    @(negedge clk_i);
    rst_async_n_i = 1'b1;
    acc = 0;
    repeat (5) begin
      @(negedge clk_i);
      acc += int'(core_start_o) + int'(host_busy_o);
    end
    chk("rst_quiet", acc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
